// File: rtl/scnn_pkg.sv
// Shared definitions for the SCNN stage-interconnect blocks.
//   state_e       : arbiter FSM encoding (idle / burst in progress)
//   DEFAULT_WIDTH : default data word width, matches the input_fifo default
package scnn_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 32;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder.
// Searches req starting at last_owner+1, wrapping modulo NUM_REQ, and returns
// the first requester found. last_owner itself is searched last.
//   req        in  NUM_REQ        request vector
//   last_owner in  $clog2(NUM_REQ) previous winner
//   winner     out $clog2(NUM_REQ) selected index (0 when any_req is low)
//   any_req    out 1              at least one request bit set
module rr_pick #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_owner,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       any_req
);

    localparam int unsigned IDXW = $clog2(NUM_REQ);

    logic [IDXW-1:0] idx;

    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = IDXW'((32'(last_owner) + i) % NUM_REQ);
            if (!any_req && req[idx]) begin
                winner  = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/input_fifo_arbiter.sv
// Round-robin arbiter sharing one input_fifo write port among NUM_REQ
// producers. A winner owns the port for a burst of up to BURST_MAX beats;
// FIFO-full stalls the burst without releasing it.
//   clk, rst      clock / asynchronous active-high reset
//   req           per-producer valid
//   req_data      producer i word on [i*WIDTH +: WIDTH]
//   req_last      producer i's current word ends its burst
//   grant         one-hot, beat from producer i accepted this cycle
//   fifo_full     downstream FIFO full flag
//   fifo_write_en FIFO write strobe
//   fifo_w_data   FIFO write data (owner's word in burst, 0 when idle)
//   busy          high while a burst is in progress
//   owner         current burst owner, valid while busy
module input_fifo_arbiter
    import scnn_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         grant,
    input  logic                       fifo_full,
    output logic                       fifo_write_en,
    output logic [WIDTH-1:0]           fifo_w_data,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] owner
);

    localparam int unsigned IDXW = $clog2(NUM_REQ);
    localparam int unsigned CNTW = $clog2(BURST_MAX) + 1;

    state_e          state_q, state_d;
    logic [IDXW-1:0] owner_q, owner_d;
    logic [IDXW-1:0] last_owner_q, last_owner_d;
    logic [CNTW-1:0] beat_cnt_q, beat_cnt_d;

    logic [IDXW-1:0] winner;
    logic            any_req;
    logic            in_burst;
    logic            owner_req;
    logic            accept;
    logic            burst_done;
    logic [CNTW-1:0] beat_next;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req        (req),
        .last_owner (last_owner_q),
        .winner     (winner),
        .any_req    (any_req)
    );

    // Accept path is combinational so a beat lands in the FIFO the same
    // cycle the producer sees its grant.
    always_comb begin
        in_burst   = (state_q == ST_BURST);
        owner_req  = req[owner_q];
        accept     = in_burst && owner_req && !fifo_full;
        beat_next  = beat_cnt_q + CNTW'(1);
        burst_done = accept && (req_last[owner_q] || (beat_next == CNTW'(BURST_MAX)));

        fifo_write_en = accept;
        grant         = '0;
        if (accept) begin
            grant[owner_q] = 1'b1;
        end
        fifo_w_data = in_burst ? req_data[owner_q*WIDTH +: WIDTH] : '0;
        busy        = in_burst;
        owner       = owner_q;
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    owner_d    = winner;
                    beat_cnt_d = '0;
                    state_d    = ST_BURST;
                end
            end
            ST_BURST: begin
                if (burst_done || !owner_req) begin
                    // Normal end or owner abandoned the burst: hand priority on.
                    last_owner_d = owner_q;
                    beat_cnt_d   = '0;
                    state_d      = ST_IDLE;
                end else if (accept) begin
                    beat_cnt_d = beat_next;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_owner_q <= IDXW'(NUM_REQ - 1);
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_input_fifo_arbiter.sv
module tb_input_fifo_arbiter;

    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned WIDTH     = 32;
    localparam int unsigned BURST_MAX = 4;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic [NUM_REQ-1:0]         req = '0;
    logic [NUM_REQ*WIDTH-1:0]   req_data = '0;
    logic [NUM_REQ-1:0]         req_last = '0;
    logic [NUM_REQ-1:0]         grant;
    logic                       fifo_full = 1'b0;
    logic                       fifo_write_en;
    logic [WIDTH-1:0]           fifo_w_data;
    logic                       busy;
    logic [1:0]                 owner;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    input_fifo_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .WIDTH     (WIDTH),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_data      (req_data),
        .req_last      (req_last),
        .grant         (grant),
        .fifo_full     (fifo_full),
        .fifo_write_en (fifo_write_en),
        .fifo_w_data   (fifo_w_data),
        .busy          (busy),
        .owner         (owner)
    );

    typedef struct {
        logic        r;
        logic [3:0]  rq;
        logic [3:0]  l;
        logic        f;
        logic [1:0]  src;
        logic [31:0] word;
        logic [3:0]  g;
        logic        we;
        logic [31:0] wd;
        logic        b;
        logic [1:0]  o;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic r, logic [3:0] rq, logic [3:0] l, logic f,
                               logic [1:0] src, logic [31:0] word, logic [3:0] g,
                               logic we, logic [31:0] wd, logic b, logic [1:0] o);
        vec_t x;
        x.r = r; x.rq = rq; x.l = l; x.f = f; x.src = src; x.word = word;
        x.g = g; x.we = we; x.wd = wd; x.b = b; x.o = o;
        return x;
    endfunction

    // Producer src offers word; every other producer offers a distinct tag.
    task automatic drive(logic [1:0] src, logic [31:0] word);
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*WIDTH +: WIDTH] = (i == int'(src)) ? word : (32'hDEAD_0000 | 32'(i));
        end
    endtask

    task automatic check(string name, logic ok, string got, string exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %s, expected %s", name, got, exp);
    endtask

    initial begin
        // Test 1: reset held 3 cycles, then idle with no requests
        for (int i = 0; i < 3; i++) tbl.push_back(v(1, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(v(0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 0));
        // Test 2: producer 0, six words, burst split at BURST_MAX
        tbl.push_back(v(0, 4'h1, 4'h0, 0, 0, 32'hA0, 4'h0, 0, 32'h0,  0, 0));
        tbl.push_back(v(0, 4'h1, 4'h0, 0, 0, 32'hA0, 4'h1, 1, 32'hA0, 1, 0));
        tbl.push_back(v(0, 4'h1, 4'h0, 0, 0, 32'hA1, 4'h1, 1, 32'hA1, 1, 0));
        tbl.push_back(v(0, 4'h1, 4'h0, 0, 0, 32'hA2, 4'h1, 1, 32'hA2, 1, 0));
        tbl.push_back(v(0, 4'h1, 4'h0, 0, 0, 32'hA3, 4'h1, 1, 32'hA3, 1, 0));
        tbl.push_back(v(0, 4'h1, 4'h0, 0, 0, 32'hA4, 4'h0, 0, 32'h0,  0, 0));
        tbl.push_back(v(0, 4'h1, 4'h0, 0, 0, 32'hA4, 4'h1, 1, 32'hA4, 1, 0));
        tbl.push_back(v(0, 4'h1, 4'h1, 0, 0, 32'hA5, 4'h1, 1, 32'hA5, 1, 0));
        tbl.push_back(v(0, 4'h0, 4'h0, 0, 0, 32'h0,  4'h0, 0, 32'h0,  0, 0));
        // Test 3: reset, then all request with single-beat bursts -> 0,1,2,3,0,...
        tbl.push_back(v(1, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 0));
        for (int k = 0; k < 8; k++) begin
            tbl.push_back(v(0, 4'hF, 4'hF, 0, 2'(k), 32'h30 + 32'(k), 4'h0, 0, 32'h0, 0, 0));
            tbl.push_back(v(0, 4'hF, 4'hF, 0, 2'(k), 32'h30 + 32'(k), 4'(1 << (k % 4)), 1,
                            32'h30 + 32'(k), 1, 2'(k)));
        end
        // Test 4: producer 2, FIFO full for 3 cycles after beat 2
        tbl.push_back(v(0, 4'h4, 4'h0, 0, 2, 32'h10, 4'h0, 0, 32'h0,  0, 0));
        tbl.push_back(v(0, 4'h4, 4'h0, 0, 2, 32'h10, 4'h4, 1, 32'h10, 1, 2));
        tbl.push_back(v(0, 4'h4, 4'h0, 0, 2, 32'h11, 4'h4, 1, 32'h11, 1, 2));
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(0, 4'h4, 4'h0, 1, 2, 32'h12, 4'h0, 0, 32'h12, 1, 2));
        tbl.push_back(v(0, 4'h4, 4'h0, 0, 2, 32'h12, 4'h4, 1, 32'h12, 1, 2));
        tbl.push_back(v(0, 4'h4, 4'h0, 0, 2, 32'h13, 4'h4, 1, 32'h13, 1, 2));
        tbl.push_back(v(0, 4'h0, 4'h0, 0, 2, 32'h0,  4'h0, 0, 32'h0,  0, 0));
        // Test 5: producer 1 abandons after 2 beats; next search starts at 2
        tbl.push_back(v(0, 4'h2, 4'h0, 0, 1, 32'h50, 4'h0, 0, 32'h0,  0, 0));
        tbl.push_back(v(0, 4'h2, 4'h0, 0, 1, 32'h50, 4'h2, 1, 32'h50, 1, 1));
        tbl.push_back(v(0, 4'h2, 4'h0, 0, 1, 32'h51, 4'h2, 1, 32'h51, 1, 1));
        tbl.push_back(v(0, 4'h0, 4'h0, 0, 1, 32'h52, 4'h0, 0, 32'h52, 1, 1));
        tbl.push_back(v(0, 4'hF, 4'hF, 0, 2, 32'h60, 4'h0, 0, 32'h0,  0, 0));
        tbl.push_back(v(0, 4'hF, 4'hF, 0, 2, 32'h60, 4'h4, 1, 32'h60, 1, 2));
        tbl.push_back(v(0, 4'h0, 4'h0, 0, 2, 32'h0,  4'h0, 0, 32'h0,  0, 0));
        // Test 6: reset in the middle of producer 3's burst
        tbl.push_back(v(0, 4'h8, 4'h0, 0, 3, 32'h70, 4'h0, 0, 32'h0,  0, 0));
        tbl.push_back(v(0, 4'h8, 4'h0, 0, 3, 32'h70, 4'h8, 1, 32'h70, 1, 3));
        tbl.push_back(v(0, 4'h8, 4'h0, 0, 3, 32'h71, 4'h8, 1, 32'h71, 1, 3));
        tbl.push_back(v(1, 4'h8, 4'h0, 0, 3, 32'h72, 4'h0, 0, 32'h0,  0, 0));
        tbl.push_back(v(1, 4'hF, 4'hF, 0, 0, 32'h80, 4'h0, 0, 32'h0,  0, 0));
        tbl.push_back(v(0, 4'hF, 4'hF, 0, 0, 32'h80, 4'h0, 0, 32'h0,  0, 0));
        tbl.push_back(v(0, 4'hF, 4'hF, 0, 0, 32'h80, 4'h1, 1, 32'h80, 1, 0));
        tbl.push_back(v(0, 4'h0, 4'h0, 0, 0, 32'h0,  4'h0, 0, 32'h0,  0, 0));

        foreach (tbl[i]) begin
            @(negedge clk);
            rst       = tbl[i].r;
            req       = tbl[i].rq;
            req_last  = tbl[i].l;
            fifo_full = tbl[i].f;
            drive(tbl[i].src, tbl[i].word);
            #1;
            check($sformatf("vec%0d", i),
                  grant == tbl[i].g && fifo_write_en == tbl[i].we && fifo_w_data == tbl[i].wd &&
                  busy == tbl[i].b && ((!tbl[i].b && !tbl[i].r) || owner == tbl[i].o),
                  $sformatf("g=%b we=%b wd=%h busy=%b own=%0d", grant, fifo_write_en,
                            fifo_w_data, busy, owner),
                  $sformatf("g=%b we=%b wd=%h busy=%b own=%0d", tbl[i].g, tbl[i].we,
                            tbl[i].wd, tbl[i].b, tbl[i].o));
        end

        // Long stall: producer 0 held off by a full FIFO, then resumes.
        @(negedge clk);
        req = 4'h1; req_last = 4'h1; fifo_full = 1'b1; drive(0, 32'h90);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("stall%0d", i), !fifo_write_en && grant == 4'h0 && busy,
                  $sformatf("we=%b g=%b busy=%b", fifo_write_en, grant, busy),
                  "we=0 g=0000 busy=1");
        end
        @(negedge clk);
        fifo_full = 1'b0;
        begin
            bit seen = 0;
            for (int i = 0; i < 4 && !seen; i++) begin
                #1;
                if (fifo_write_en) seen = 1;
                else @(negedge clk);
            end
            check("resume_write", seen && fifo_w_data == 32'h90 && grant == 4'h1,
                  $sformatf("seen=%b wd=%h g=%b", seen, fifo_w_data, grant),
                  "seen=1 wd=00000090 g=0001");
        end
        @(negedge clk);
        req = 4'h0;
        #1;
        check("release", !busy && !fifo_write_en,
              $sformatf("busy=%b we=%b", busy, fifo_write_en), "busy=0 we=0");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
